// File: rtl/phaser_pkg.sv
// phaser_pkg: shared encodings for the phaser scan controller
// (scan state, phaser unfire code, wait-state watchdog limit).
package phaser_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CHECK     = 4'd1,
        S_SET       = 4'd2,
        S_WAIT_UNF  = 4'd3,
        S_RELEASE   = 4'd4,
        S_WAIT_IDLE = 4'd5,
        S_DWELL     = 4'd6,
        S_JUDGE     = 4'd7,
        S_ADVANCE   = 4'd8,
        S_DRAIN     = 4'd9,
        S_DONE      = 4'd10
    } scan_state_e;

    localparam logic [2:0]  DPS_UNFIRE   = 3'h6;
    localparam logic [15:0] SCAN_TIMEOUT = 16'hFFFF;

endpackage

// File: rtl/phaser_scan_errcnt.sv
// phaser_scan_errcnt: dwell timer plus saturating error counter; both are held
// at zero while clear is high and advance only while run is high.
module phaser_scan_errcnt #(
    parameter int MXDWELL = 16
) (
    input  logic               clock,
    input  logic               global_reset_n,
    input  logic               clear,
    input  logic               run,
    input  logic               err_pulse,
    input  logic [MXDWELL-1:0] dwell,
    output logic [MXDWELL-1:0] count,
    output logic               expired
);

    localparam logic [MXDWELL-1:0] DW_ONE = MXDWELL'(1);

    logic [MXDWELL-1:0] timer_q, timer_d;
    logic [MXDWELL-1:0] count_q, count_d;
    logic [MXDWELL-1:0] dwell_last;

    // A zero dwell still spends one clock counting.
    always_comb begin
        dwell_last = (dwell == '0) ? '0 : dwell - DW_ONE;
        expired    = run && (timer_q == dwell_last);
        timer_d    = timer_q;
        count_d    = count_q;
        if (clear) begin
            timer_d = '0;
            count_d = '0;
        end else if (run) begin
            timer_d = timer_q + DW_ONE;
            if (err_pulse && (count_q != '1)) begin
                count_d = count_q + DW_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            timer_q <= '0;
            count_q <= '0;
        end else begin
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/phaser_scan.sv
// phaser_scan: steps the phaser across [phase_first, phase_last], counts receiver errors at each
// point and keeps the lowest-error phase. Define PHASER_SCAN_TIMEOUT_EN for a wait-state watchdog.
module phaser_scan
    import phaser_pkg::*;
#(
    parameter int MXPHASE = 11,
    parameter int MXDWELL = 16
) (
    input  logic               clock,
    input  logic               global_reset_n,
    input  logic               scan_start,
    input  logic               scan_abort,
    input  logic [MXPHASE-1:0] phase_first,
    input  logic [MXPHASE-1:0] phase_last,
    input  logic [MXPHASE-1:0] phase_step,
    input  logic [MXDWELL-1:0] dwell,
    input  logic               err_pulse,
    output logic               fire,
    output logic [MXPHASE-1:0] phase,
    input  logic               busy,
    input  logic [2:0]         dps_sm_vec,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               scan_err,
    output logic [MXPHASE-1:0] best_phase,
    output logic [MXDWELL-1:0] best_errs
);

    scan_state_e        state_q, state_d;
    logic [MXPHASE-1:0] cur_q, cur_d;
    logic [MXPHASE-1:0] phase_q, phase_d;
    logic               fire_q, fire_d;
    logic               scan_busy_q, scan_busy_d;
    logic               scan_done_q, scan_done_d;
    logic               scan_err_q, scan_err_d;
    logic [MXPHASE-1:0] best_phase_q, best_phase_d;
    logic [MXDWELL-1:0] best_errs_q, best_errs_d;

    logic               bad_range;
    logic               abort_hit;
    logic [MXPHASE-1:0] step_eff;
    logic [MXPHASE:0]   next_phase;
    logic               adv_end;
    logic               wd_timeout;

    logic               cnt_run;
    logic               cnt_clear;
    logic [MXDWELL-1:0] cnt_count;
    logic               cnt_expired;

    assign bad_range  = phase_first > phase_last;
    assign abort_hit  = scan_abort && (state_q != S_IDLE);
    assign step_eff   = (phase_step == '0) ? MXPHASE'(1) : phase_step;
    // One extra bit so a step past the top of the phase range is seen as a carry, not a wrap.
    assign next_phase = {1'b0, cur_q} + {1'b0, step_eff};
    assign adv_end    = next_phase[MXPHASE] || (next_phase[MXPHASE-1:0] > phase_last);

    assign cnt_run   = (state_q == S_DWELL);
    assign cnt_clear = !cnt_run;

    phaser_scan_errcnt #(
        .MXDWELL(MXDWELL)
    ) u_errcnt (
        .clock         (clock),
        .global_reset_n(global_reset_n),
        .clear         (cnt_clear),
        .run           (cnt_run),
        .err_pulse     (err_pulse),
        .dwell         (dwell),
        .count         (cnt_count),
        .expired       (cnt_expired)
    );

`ifdef PHASER_SCAN_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
    logic        in_wait;

    assign in_wait    = (state_q == S_WAIT_UNF) || (state_q == S_WAIT_IDLE);
    assign wd_timeout = in_wait && (wd_q == SCAN_TIMEOUT);

    always_comb begin
        wd_d = '0;
        if (in_wait && (state_d == state_q)) begin
            wd_d = wd_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end
`else
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      if (scan_start) state_d = S_CHECK;
            S_CHECK:     state_d = bad_range ? S_DONE : S_SET;
            S_SET:       state_d = S_WAIT_UNF;
            S_WAIT_UNF:  if (dps_sm_vec == DPS_UNFIRE) state_d = S_RELEASE;
            S_RELEASE:   state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (!busy) state_d = S_DWELL;
            S_DWELL:     if (cnt_expired) state_d = S_JUDGE;
            S_JUDGE:     state_d = S_ADVANCE;
            S_ADVANCE:   state_d = adv_end ? S_DONE : S_SET;
            S_DRAIN:     if (!busy) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        if (abort_hit || wd_timeout) begin
            state_d = S_DRAIN;
        end
    end

    always_comb begin
        cur_d        = cur_q;
        phase_d      = phase_q;
        fire_d       = fire_q;
        scan_err_d   = scan_err_q;
        scan_done_d  = scan_done_q;
        best_phase_d = best_phase_q;
        best_errs_d  = best_errs_q;
        unique case (state_q)
            S_IDLE: begin
                if (scan_start) begin
                    scan_done_d  = 1'b0;
                    scan_err_d   = 1'b0;
                    cur_d        = phase_first;
                    best_errs_d  = '1;
                    best_phase_d = phase_first;
                end
            end
            S_CHECK:   if (bad_range) scan_err_d = 1'b1;
            S_SET: begin
                phase_d = cur_q;
                fire_d  = 1'b1;
            end
            S_RELEASE: fire_d = 1'b0;
            // Strict compare: on a tie the earlier, lower phase stays best.
            S_JUDGE: begin
                if (cnt_count < best_errs_q) begin
                    best_errs_d  = cnt_count;
                    best_phase_d = cur_q;
                end
            end
            S_ADVANCE: if (!adv_end) cur_d = next_phase[MXPHASE-1:0];
            S_DRAIN:   if (!busy) scan_err_d = 1'b1;
            default: ;
        endcase
        if (abort_hit) begin
            fire_d = 1'b0;
        end
        if (wd_timeout) begin
            fire_d     = 1'b0;
            scan_err_d = 1'b1;
        end
        // scan_done rises on entry to done and is held until the next start.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            scan_done_d = 1'b1;
        end
        scan_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge global_reset_n) begin
        if (!global_reset_n) begin
            cur_q        <= '0;
            phase_q      <= '0;
            fire_q       <= 1'b0;
            scan_busy_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_err_q   <= 1'b0;
            best_phase_q <= '0;
            best_errs_q  <= '0;
        end else begin
            cur_q        <= cur_d;
            phase_q      <= phase_d;
            fire_q       <= fire_d;
            scan_busy_q  <= scan_busy_d;
            scan_done_q  <= scan_done_d;
            scan_err_q   <= scan_err_d;
            best_phase_q <= best_phase_d;
            best_errs_q  <= best_errs_d;
        end
    end

    assign fire       = fire_q;
    assign phase      = phase_q;
    assign scan_busy  = scan_busy_q;
    assign scan_done  = scan_done_q;
    assign scan_err   = scan_err_q;
    assign best_phase = best_phase_q;
    assign best_errs  = best_errs_q;

endmodule
